weight_stream_source: RTL and testbench

Parametrised, back-pressure-aware weight streamer for MASE linear/attention layers. It walks a weight tensor stored in a pipelined ROM as tiles of PARALLELISM_DIM_0 × PARALLELISM_DIM_1 elements and emits one tile per valid/ready beat. It supports a programmable pass count, a per-pass last marker and a start/done control handshake. It replaces the free-running, always-valid weight sources, which drop beats under back-pressure.

---
 rtl/weight_stream_pkg.sv | 21 ++
 rtl/weight_stream_source_if.sv | 26 ++
 rtl/weight_stream_fifo.sv | 60 ++++++
 rtl/weight_stream_source.sv | 154 +++++++++++++++
 tb/tb_weight_stream_source.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_stream_pkg.sv
// rtl/weight_stream_pkg.sv - shared types and sizing helpers for the weight streamer
package weight_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Number of tiles in one pass over the tensor.
    function automatic int calc_depth(input int t0, input int t1, input int p0, input int p1);
        return (t0 / p0) * (t1 / p1);
    endfunction

    // Room for every read the ROM pipeline can hold plus one registered and one draining word,
    // which is what keeps issue bubble-free with the consumer always ready.
    function automatic int calc_fifo_depth(input int rom_latency);
        return rom_latency + 2;
    endfunction

endpackage

// File: rtl/weight_stream_source_if.sv
// rtl/weight_stream_source_if.sv - tile output stream (data, valid, last, ready)
// Ports: data_out[N] elements of PRECISION bits, data_out_valid, data_out_last from the
// source; data_out_ready from the consumer.
interface weight_stream_source_if #(
    parameter int PRECISION = 16,
    parameter int N         = 1
);
    logic [N-1:0][PRECISION-1:0] data_out;
    logic                        data_out_valid;
    logic                        data_out_last;
    logic                        data_out_ready;

    modport master (
        output data_out,
        output data_out_valid,
        output data_out_last,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  data_out_last,
        output data_out_ready
    );
endinterface

// File: rtl/weight_stream_fifo.sv
// rtl/weight_stream_fifo.sv - first-word-fall-through FIFO with occupancy count
// Ports: clk, rst (sync, active-high); push/push_data write; pop/pop_data read, pop_data
// shows the head word whenever !empty; count is the current occupancy.
module weight_stream_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/weight_stream_source.sv
// rtl/weight_stream_source.sv - back-pressure-aware tiled weight streamer over a pipelined ROM
// Ports: clk, rst (sync, active-high); start/num_passes request, busy/done status;
// rom_addr/rom_ce/rom_q ROM port; out_if tile stream (data_out, valid, last, ready).
module weight_stream_source
    import weight_stream_pkg::*;
#(
    parameter int PRECISION         = 16,
    parameter int TENSOR_SIZE_DIM_0 = 32,
    parameter int TENSOR_SIZE_DIM_1 = 1,
    parameter int PARALLELISM_DIM_0 = 1,
    parameter int PARALLELISM_DIM_1 = 1,
    parameter int ROM_LATENCY       = 2,
    parameter int PASS_WIDTH        = 8,
    localparam int N     = PARALLELISM_DIM_0 * PARALLELISM_DIM_1,
    localparam int DEPTH = calc_depth(TENSOR_SIZE_DIM_0, TENSOR_SIZE_DIM_1,
                                      PARALLELISM_DIM_0, PARALLELISM_DIM_1),
    localparam int AW    = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PASS_WIDTH-1:0]  num_passes,
    output logic                   busy,
    output logic                   done,
    output logic [AW-1:0]          rom_addr,
    output logic                   rom_ce,
    input  logic [PRECISION*N-1:0] rom_q,
    weight_stream_source_if.master out_if
);
    localparam int FIFO_DEPTH = calc_fifo_depth(ROM_LATENCY);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int FW         = PRECISION * N + 1;

    state_t                 state;
    state_t                 state_next;
    logic [AW-1:0]          addr;
    logic [PASS_WIDTH-1:0]  pass_cnt;
    logic [PASS_WIDTH-1:0]  passes_r;
    logic [ROM_LATENCY-1:0] infl_v;
    logic [ROM_LATENCY-1:0] infl_last;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          fifo_count;
    logic [FW-1:0]          fifo_dout;
    logic                   fifo_empty;
    logic                   credit;
    logic                   issue;
    logic                   addr_last;
    logic                   final_pass;
    logic                   pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            inflight = inflight + CW'(infl_v[i]);
        end
    end

    // Every read counted against the FIFO before it is issued, so a full pipeline can
    // always land even if the consumer stops.
    assign credit     = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
    assign addr_last  = (addr == AW'(DEPTH - 1));
    assign final_pass = (passes_r != '0) && (pass_cnt == passes_r - PASS_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                issue = credit;
                if (issue && addr_last && final_pass) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((infl_v == '0) && fifo_empty) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            pass_cnt  <= '0;
            passes_r  <= '0;
            infl_v    <= '0;
            infl_last <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                addr     <= '0;
                pass_cnt <= '0;
                passes_r <= num_passes;
            end else if (issue) begin
                if (addr_last) begin
                    addr     <= '0;
                    pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                end else begin
                    addr <= addr + AW'(1);
                end
            end
            // Flags age one stage per cycle; the oldest stage lines up with rom_q.
            infl_v[0]    <= issue;
            infl_last[0] <= issue && addr_last;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                infl_v[i]    <= infl_v[i-1];
                infl_last[i] <= infl_last[i-1];
            end
        end
    end

    weight_stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (infl_v[ROM_LATENCY-1]),
        .push_data ({infl_last[ROM_LATENCY-1], rom_q}),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy     = (state != IDLE);
    assign rom_ce   = busy;
    assign rom_addr = addr;

    assign pop                   = out_if.data_out_valid && out_if.data_out_ready;
    assign out_if.data_out_valid = !fifo_empty;
    // Packed element j maps onto bits [PRECISION*j +: PRECISION] of the ROM word; outputs
    // are forced to zero when empty so stale storage never shows.
    assign out_if.data_out       = fifo_empty ? '0 : fifo_dout[FW-2:0];
    assign out_if.data_out_last  = !fifo_empty && fifo_dout[FW-1];

endmodule

// File: tb/tb_weight_stream_source.sv
// tb/tb_weight_stream_source.sv - self-checking bench for weight_stream_source
module tb_weight_stream_source;
    localparam int DEPTH = 8;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_passes = 8'd0;
    logic        busy;
    logic        done;
    logic        rom_ce;
    logic [AW-1:0] rom_addr;
    logic [31:0] rom_q;
    logic [31:0] q1;

    weight_stream_source_if #(.PRECISION(8), .N(4)) sif();

    weight_stream_source #(
        .PRECISION         (8),
        .TENSOR_SIZE_DIM_0 (8),
        .TENSOR_SIZE_DIM_1 (4),
        .PARALLELISM_DIM_0 (2),
        .PARALLELISM_DIM_1 (2),
        .ROM_LATENCY       (2),
        .PASS_WIDTH        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_passes (num_passes),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_ce     (rom_ce),
        .rom_q      (rom_q),
        .out_if     (sif)
    );

    always #5 clk = ~clk;

    // ROM word k: element j holds (k<<4)|j.
    function automatic logic [31:0] word(input int k);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'((k << 4) | j);
        return w;
    endfunction

    always @(posedge clk) begin
        if (rom_ce) begin
            q1    <= word(int'(rom_addr));
            rom_q <= q1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int beats = 0, lasts = 0, done_cnt = 0, done_cyc = 0, last_pop_cyc = 0, exp_total = 0;
    int rmode = 0;
    bit prev_stall = 0;
    logic [31:0] prev_data;
    logic prev_last;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
        end
    endtask

    task automatic set_mode(input int m);
        rmode = m;
        sif.data_out_ready = (m == 0) ? 1'b1 : (m == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        set_mode(rmode);
    endtask

    task automatic clear_model(input int total);
        beats = 0; lasts = 0; done_cnt = 0; exp_total = total;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        chk("done_timeout", 64'(done_cnt > 0), 1);
    endtask

    // Model: beat b must carry word(b mod DEPTH), last on every DEPTH-th beat.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(sif.data_out_valid), 1);
                chk("stall_data", 64'(sif.data_out), 64'(prev_data));
                chk("stall_last", 64'(sif.data_out_last), 64'(prev_last));
            end
            if (sif.data_out_valid && sif.data_out_ready) begin
                chk("beat_data", 64'(sif.data_out), 64'(word(beats % DEPTH)));
                chk("beat_last", 64'(sif.data_out_last), 64'((beats % DEPTH) == DEPTH - 1));
                if (exp_total != 0) chk("beat_overflow", 64'(beats < exp_total), 1);
                if (beats == 0) chk("pin_beat0_e3", 64'(sif.data_out[3]), 64'h03);
                if (beats == 5) chk("pin_beat5_e2", 64'(sif.data_out[2]), 64'h52);
                if (sif.data_out_last) lasts++;
                beats++;
                last_pop_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_beats", 64'(beats), 64'(exp_total));
                chk("done_after_pop", 64'(cyc - last_pop_cyc), 1);
            end
            prev_stall = sif.data_out_valid && !sif.data_out_ready;
            prev_data  = sif.data_out;
            prev_last  = sif.data_out_last;
        end
    end

    initial begin
        int start_cyc;
        int bubbles;
        int idle_cycles;
        set_mode(0);
        repeat (3) step();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_rom_ce", 64'(rom_ce), 0);
        chk("rst_rom_addr", 64'(rom_addr), 0);
        chk("rst_valid", 64'(sif.data_out_valid), 0);
        chk("rst_last", 64'(sif.data_out_last), 0);
        chk("rst_data", 64'(sif.data_out), 0);
        rst = 1'b0;
        step();

        // Single pass, ready high: addresses in order, first valid in cycle 4.
        clear_model(8);
        num_passes = 8'd1;
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("issue_addr", 64'(rom_addr), 64'(k - 1));
            if (k == 1) chk("busy_c1", 64'(busy), 1);
            if (k == 3) chk("valid_c3", 64'(sif.data_out_valid), 0);
            if (k == 4) chk("valid_c4", 64'(sif.data_out_valid), 1);
            step();
        end
        wait_done(200);
        chk("done_cycle", 64'(done_cyc - start_cyc), 12);
        chk("beats_single", 64'(beats), 8);
        chk("lasts_single", 64'(lasts), 1);
        step();
        chk("idle_after_done", 64'(busy), 0);

        // Three passes with random ready, plus a start pulse while busy.
        clear_model(24);
        num_passes = 8'd3;
        set_mode(1);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        num_passes = 8'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_pulse", 64'(busy), 1);
        wait_done(3000);
        step();
        chk("beats_multi", 64'(beats), 24);
        chk("lasts_multi", 64'(lasts), 3);
        chk("done_once", 64'(done_cnt), 1);

        // Continuous mode: no bubbles, never done.
        clear_model(0);
        num_passes = 8'd0;
        set_mode(0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        bubbles = 0;
        idle_cycles = 0;
        for (int k = 0; k < 1000; k++) begin
            if (!sif.data_out_valid) bubbles++;
            if (!busy) idle_cycles++;
            step();
        end
        chk("cont_bubbles", 64'(bubbles), 0);
        chk("cont_idle", 64'(idle_cycles), 0);
        chk("cont_done", 64'(done_cnt), 0);
        chk("cont_beats", 64'(beats >= 1000), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("cont_rst_busy", 64'(busy), 0);

        // Reset with the FIFO full and the consumer stalled, then replay.
        clear_model(8);
        num_passes = 8'd1;
        set_mode(2);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("full_valid", 64'(sif.data_out_valid), 1);
        chk("credit_addr", 64'(rom_addr), 4);
        chk("full_busy", 64'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", 64'(sif.data_out_valid), 0);
        chk("midrst_busy", 64'(busy), 0);
        clear_model(8);
        set_mode(0);
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
        chk("replay_addr0", 64'(rom_addr), 0);
        wait_done(200);
        chk("replay_done_cycle", 64'(done_cyc - start_cyc), 12);
        chk("replay_beats", 64'(beats), 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
